rv32i_stage_sequencer: RTL and testbench

RV32I_STAGE_SEQUENCER -- requirements
Module: rv32i_stage_sequencer

---
 rtl/rv32i_stage_sequencer.sv | 143 ++++++++++++++
 tb/tb_rv32i_stage_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_stage_sequencer.sv
// RV32I multi-cycle stage sequencer: fetch, two-phase decode, execute,
// optional data-memory access and writeback, with a sticky trap state.
// Optional feature: define SEQ_RETIRE_COUNTER_EN to add o_retired_count,
// a WORD_SIZE-bit wrapping count of o_pc_update pulses.
module rv32i_stage_sequencer #(
  parameter logic [7:0]  MEM_TIMEOUT = 8'd255,
  parameter int unsigned WORD_SIZE   = 32
) (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic       o_fetch_req,
  input  logic       i_fetch_ack,
  output logic       o_decode_pause,
  input  logic       i_invalid_instruction,
  input  logic       i_ld_type,
  input  logic       i_str_type,
  input  logic       i_writeback_en,
  output logic       o_ex_en,
  output logic       o_mem_req,
  input  logic       i_mem_ack,
  output logic       o_wb_en,
  output logic       o_pc_update,
  output logic       o_trap,
  output logic [2:0] o_state
`ifdef SEQ_RETIRE_COUNTER_EN
  ,
  output logic [WORD_SIZE-1:0] o_retired_count
`endif
);

  localparam logic [2:0] S_FETCH     = 3'd0;
  localparam logic [2:0] S_DEC_OPC   = 3'd1;
  localparam logic [2:0] S_DEC_OPR   = 3'd2;
  localparam logic [2:0] S_EXECUTE   = 3'd3;
  localparam logic [2:0] S_MEMORY    = 3'd4;
  localparam logic [2:0] S_WRITEBACK = 3'd5;
  localparam logic [2:0] S_TRAP      = 3'd6;

  if (WORD_SIZE < 1) begin : g_bad_word_size
    $error("WORD_SIZE must be at least 1");
  end

  logic [2:0] state_q, state_d;
  logic       ld_q, ld_d;
  logic       st_q, st_d;
  logic [7:0] wait_q, wait_d;
  logic       pc_upd;

  // Next-state, class-flag capture and memory wait counting.
  // Only load/store need to survive EXECUTE: the writeback decision is made
  // there directly, and a completed load always proceeds to WRITEBACK.
  always_comb begin
    state_d = state_q;
    ld_d    = ld_q;
    st_d    = st_q;
    wait_d  = wait_q;
    pc_upd  = 1'b0;
    case (state_q)
      S_FETCH:   if (i_fetch_ack) state_d = S_DEC_OPC;
      S_DEC_OPC: state_d = S_DEC_OPR;
      S_DEC_OPR: state_d = i_invalid_instruction ? S_TRAP : S_EXECUTE;
      S_EXECUTE: begin
        ld_d   = i_ld_type;
        st_d   = i_str_type & ~i_ld_type;
        wait_d = '0;
        if (i_ld_type | i_str_type) begin
          state_d = S_MEMORY;
        end else if (i_writeback_en) begin
          state_d = S_WRITEBACK;
        end else begin
          state_d = S_FETCH;
          pc_upd  = 1'b1;
        end
      end
      S_MEMORY: begin
        if (i_mem_ack) begin
          if (ld_q) begin
            state_d = S_WRITEBACK;
          end else if (st_q) begin
            state_d = S_FETCH;
            pc_upd  = 1'b1;
          end else begin
            state_d = S_TRAP;
          end
        end else if (wait_q == MEM_TIMEOUT) begin
          state_d = S_TRAP;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end
      S_WRITEBACK: begin
        state_d = S_FETCH;
        pc_upd  = 1'b1;
      end
      S_TRAP:  state_d = S_TRAP;
      default: state_d = S_TRAP;
    endcase
    if (i_rst) pc_upd = 1'b0;
  end

  // State and class-flag registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_FETCH;
      ld_q    <= 1'b0;
      st_q    <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      st_q    <= st_d;
      wait_q  <= wait_d;
    end
  end

  assign o_state        = state_q;
  assign o_fetch_req    = (state_q == S_FETCH);
  assign o_decode_pause = ~((state_q == S_DEC_OPC) | (state_q == S_DEC_OPR));
  assign o_ex_en        = (state_q == S_EXECUTE);
  assign o_mem_req      = (state_q == S_MEMORY);
  assign o_wb_en        = (state_q == S_WRITEBACK) & ~i_rst;
  assign o_trap         = (state_q == S_TRAP);
  assign o_pc_update    = pc_upd;

`ifdef SEQ_RETIRE_COUNTER_EN
  logic [WORD_SIZE-1:0] retired_q, retired_d;

  // Retired-instruction count, one per PC advance, wrapping naturally.
  always_comb begin
    retired_d = retired_q;
    if (pc_upd) retired_d = retired_q + 1'b1;
  end

  // Retired counter register.
  always_ff @(posedge i_clk) begin
    if (i_rst) retired_q <= '0;
    else       retired_q <= retired_d;
  end

  assign o_retired_count = retired_q;
`endif

endmodule

// File: tb/tb_rv32i_stage_sequencer.sv
// Scoreboard bench for rv32i_stage_sequencer: directed per-cycle vectors
// push expected state/pc_update into a queue; a negedge monitor pops and
// compares the full output set.
module tb_rv32i_stage_sequencer;

  localparam logic [7:0] TMO = 8'd4;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       o_fetch_req, i_fetch_ack, o_decode_pause, i_invalid_instruction;
  logic       i_ld_type, i_str_type, i_writeback_en;
  logic       o_ex_en, o_mem_req, i_mem_ack, o_wb_en, o_pc_update, o_trap;
  logic [2:0] o_state;
`ifdef SEQ_RETIRE_COUNTER_EN
  logic [31:0] o_retired_count;
`endif

  rv32i_stage_sequencer #(.MEM_TIMEOUT(TMO), .WORD_SIZE(32)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .o_fetch_req(o_fetch_req), .i_fetch_ack(i_fetch_ack),
    .o_decode_pause(o_decode_pause),
    .i_invalid_instruction(i_invalid_instruction),
    .i_ld_type(i_ld_type), .i_str_type(i_str_type),
    .i_writeback_en(i_writeback_en),
    .o_ex_en(o_ex_en), .o_mem_req(o_mem_req), .i_mem_ack(i_mem_ack),
    .o_wb_en(o_wb_en), .o_pc_update(o_pc_update), .o_trap(o_trap),
    .o_state(o_state)
`ifdef SEQ_RETIRE_COUNTER_EN
    , .o_retired_count(o_retired_count)
`endif
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          is_cnt;
    logic [2:0]  st;
    logic        pc;
    logic        rst;
    int unsigned cnt;
    string       name;
  } exp_t;

  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;

  // Expected outputs from the state table: {state, fetch_req, pause, ex_en,
  // mem_req, wb_en, pc_update, trap}.
  function automatic logic [9:0] model(input logic [2:0] s, input logic pc,
                                       input logic rst);
    return {s, s == 3'd0, !(s == 3'd1 || s == 3'd2), s == 3'd3, s == 3'd4,
            (s == 3'd5) && !rst, pc, s == 3'd6};
  endfunction

  // in = {rst, fetch_ack, mem_ack, invalid, ld, st, wb}
  task automatic step(input string nm, input logic [6:0] in,
                      input logic [2:0] es, input logic epc);
    {i_rst, i_fetch_ack, i_mem_ack, i_invalid_instruction,
     i_ld_type, i_str_type, i_writeback_en} = in;
    q.push_back('{1'b0, es, epc, in[6], 0, nm});
    @(posedge i_clk); #1;
  endtask

  task automatic check_count(input string nm, input int unsigned c);
`ifdef SEQ_RETIRE_COUNTER_EN
    q.push_back('{1'b1, 3'd0, 1'b0, 1'b0, c, nm});
`endif
  endtask

  task automatic do_reset();
    {i_rst, i_fetch_ack, i_mem_ack, i_invalid_instruction,
     i_ld_type, i_str_type, i_writeback_en} = 7'b1000000;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  exp_t       mon_e;
  logic [9:0] act_v, exp_v;

  // Monitor: compare every pending expectation at the falling edge.
  always @(negedge i_clk) begin
    while (q.size() > 0) begin
      mon_e = q.pop_front();
      if (!mon_e.is_cnt) begin
        vectors++;
        act_v = {o_state, o_fetch_req, o_decode_pause, o_ex_en, o_mem_req,
                 o_wb_en, o_pc_update, o_trap};
        exp_v = model(mon_e.st, mon_e.pc, mon_e.rst);
        if (act_v !== exp_v) begin
          miscompares++;
          $display("FAIL %s: got %b expected %b (state,freq,pause,ex,mem,wb,pc,trap)",
                   mon_e.name, act_v, exp_v);
        end
      end
`ifdef SEQ_RETIRE_COUNTER_EN
      else begin
        vectors++;
        if (o_retired_count !== mon_e.cnt) begin
          miscompares++;
          $display("FAIL %s: retired count got %0d expected %0d",
                   mon_e.name, o_retired_count, mon_e.cnt);
        end
      end
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    {i_rst, i_fetch_ack, i_mem_ack, i_invalid_instruction,
     i_ld_type, i_str_type, i_writeback_en} = 7'b1000000;
    @(posedge i_clk); #1;
    do_reset();

    // ALU op with writeback, then stray acks and ALU op without writeback
    step("t1_fetch",  7'b0100000, 3'd0, 1'b0);
    step("t1_dopc",   7'b0000000, 3'd1, 1'b0);
    step("t1_dopr",   7'b0000000, 3'd2, 1'b0);
    step("t1_exec",   7'b0000001, 3'd3, 1'b0);
    step("t1_wb",     7'b0000000, 3'd5, 1'b1);
    check_count("t1_count", 1);
    step("t34_mack",  7'b0010000, 3'd0, 1'b0);
    step("t34_fetch", 7'b0100000, 3'd0, 1'b0);
    step("t34_dopc",  7'b0000000, 3'd1, 1'b0);
    step("t34_dopr",  7'b0000000, 3'd2, 1'b0);
    step("t34_exec",  7'b0100000, 3'd3, 1'b1);
    check_count("t34_count", 2);
    step("t34_after", 7'b0000000, 3'd0, 1'b0);

    // Load+store together treated as load, ack after 3 wait cycles
    do_reset();
    step("t2_fetch",  7'b0100000, 3'd0, 1'b0);
    step("t2_dopc",   7'b0000000, 3'd1, 1'b0);
    step("t2_dopr",   7'b0000000, 3'd2, 1'b0);
    step("t2_exec",   7'b0000110, 3'd3, 1'b0);
    step("t2_mem0",   7'b0000000, 3'd4, 1'b0);
    step("t2_mem1",   7'b0000000, 3'd4, 1'b0);
    step("t2_mem2",   7'b0000000, 3'd4, 1'b0);
    step("t2_mem3",   7'b0010000, 3'd4, 1'b0);
    step("t2_wb",     7'b0000000, 3'd5, 1'b1);
    check_count("t2_count", 1);
    step("t2_after",  7'b0000000, 3'd0, 1'b0);

    // Store with immediate ack
    do_reset();
    step("t3_fetch",  7'b0100000, 3'd0, 1'b0);
    step("t3_dopc",   7'b0000000, 3'd1, 1'b0);
    step("t3_dopr",   7'b0000000, 3'd2, 1'b0);
    step("t3_exec",   7'b0000010, 3'd3, 1'b0);
    step("t3_mem0",   7'b0010000, 3'd4, 1'b1);
    check_count("t3_count", 1);
    step("t3_after",  7'b0000000, 3'd0, 1'b0);

    // Store timeout: five MEMORY cycles then sticky TRAP ignoring acks
    do_reset();
    step("t4_fetch",  7'b0100000, 3'd0, 1'b0);
    step("t4_dopc",   7'b0000000, 3'd1, 1'b0);
    step("t4_dopr",   7'b0000000, 3'd2, 1'b0);
    step("t4_exec",   7'b0000010, 3'd3, 1'b0);
    for (int i = 0; i < 5; i++) step("t4_memwait", 7'b0000000, 3'd4, 1'b0);
    for (int i = 0; i < 3; i++) step("t4_trap",    7'b0110111, 3'd6, 1'b0);
    check_count("t4_count", 0);

    // Ack arriving in the timeout cycle wins
    do_reset();
    step("t5_fetch",  7'b0100000, 3'd0, 1'b0);
    step("t5_dopc",   7'b0000000, 3'd1, 1'b0);
    step("t5_dopr",   7'b0000000, 3'd2, 1'b0);
    step("t5_exec",   7'b0000010, 3'd3, 1'b0);
    for (int i = 0; i < 4; i++) step("t5_memwait", 7'b0000000, 3'd4, 1'b0);
    step("t5_mem_lastack", 7'b0010000, 3'd4, 1'b1);
    step("t5_after",  7'b0000000, 3'd0, 1'b0);

    // Illegal instruction traps from DEC_OPR, execute never enabled
    do_reset();
    step("t6_fetch",  7'b0100000, 3'd0, 1'b0);
    step("t6_dopc",   7'b0000000, 3'd1, 1'b0);
    step("t6_dopr",   7'b0001001, 3'd2, 1'b0);
    step("t6_trap0",  7'b0000001, 3'd6, 1'b0);
    step("t6_trap1",  7'b0100000, 3'd6, 1'b0);

    // Reset during MEMORY with ack abandons the load
    do_reset();
    step("t7_fetch",  7'b0100000, 3'd0, 1'b0);
    step("t7_dopc",   7'b0000000, 3'd1, 1'b0);
    step("t7_dopr",   7'b0000000, 3'd2, 1'b0);
    step("t7_exec",   7'b0000100, 3'd3, 1'b0);
    step("t7_rstmem", 7'b1010000, 3'd4, 1'b0);
    step("t7_after",  7'b0000000, 3'd0, 1'b0);
    check_count("t7_count", 0);
    step("t7_hold",   7'b0000000, 3'd0, 1'b0);

    // Reset during WRITEBACK suppresses write enable and PC advance
    step("t8_fetch",  7'b0100000, 3'd0, 1'b0);
    step("t8_dopc",   7'b0000000, 3'd1, 1'b0);
    step("t8_dopr",   7'b0000000, 3'd2, 1'b0);
    step("t8_exec",   7'b0000001, 3'd3, 1'b0);
    step("t8_rstwb",  7'b1000000, 3'd5, 1'b0);
    step("t8_after",  7'b0000000, 3'd0, 1'b0);
    check_count("t8_count", 0);
    step("t8_hold",   7'b0000000, 3'd0, 1'b0);

    @(negedge i_clk); #1;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
